// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//
// Groups the byte-stream handshake and the instruction-memory word-write bus
// of the program loader.
//
//   in_valid  stream byte valid                (environment -> loader)
//   in_data   stream byte                      (environment -> loader)
//   in_ready  loader can accept a byte         (loader -> environment)
//   wr_en     one-cycle memory write strobe    (loader -> memory)
//   wr_addr   word-aligned byte address        (loader -> memory)
//   wr_data   packed little-endian word        (loader -> memory)
//   wr_be     byte enables, bit i = lane i     (loader -> memory)
//
// Modports:
//   master  the loader's view (drives in_ready and the write bus)
//   slave   the environment's view (drives the byte stream, sees writes)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);

  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_ready;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_be;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_be
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  wr_be
  );

endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Loads a byte stream into the byte-addressed, little-endian instruction
// memory. Bytes arrive over a valid/ready handshake and are packed four at a
// time into a 32-bit word (lowest address in bits [7:0]); each packed word is
// written with one strobe plus byte enables. The CPU is held in reset while a
// load is in progress.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle load request, only looked at while idle
//   base_addr  start byte address, bits [1:0] ignored
//   len_bytes  number of bytes to load (0..MEM_BYTES)
//   bus        imem_loader_if.master: byte stream in, word writes out
//   busy       load in progress
//   cpu_hold   CPU reset request, same as busy
//   done       one-cycle pulse at the end of a load
//   err        one-cycle pulse when a start is rejected (range overflow)
//   checksum   byte sum (mod 256) of the current or most recent load
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, the running checksum is built;
//                       otherwise checksum is tied to zero.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [12:0]           len_bytes,
  imem_loader_if.master         bus,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            checksum
);

  localparam int OFF_W = $clog2(MEM_BYTES);
  localparam int LEN_W = 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next;

  logic [ADDR_WIDTH-1:0]      addr_r;
  logic [LEN_W-1:0]           remaining_r;
  logic [1:0]                 lane_r;
  logic [3:0][BYTE_WIDTH-1:0] word_r;
  logic [3:0]                 be_r;

  logic [ADDR_WIDTH-1:0] aligned_base_s;
  logic [OFF_W-1:0]      aligned_off_s;
  logic [LEN_W-1:0]      end_off_s;
  logic                  range_bad_s;
  logic                  accept_s;
  logic                  start_bad_s;
  logic                  start_ok_s;
  logic                  start_load_s;

  // The low two address bits are forced to zero; only the offset inside the
  // memory takes part in the range check, in 13-bit arithmetic (max offset
  // 4092 plus max length 4096 still fits without overflow).
  assign aligned_base_s = base_addr & ~(ADDR_WIDTH'(32'd3));
  assign aligned_off_s  = aligned_base_s[OFF_W-1:0];
  assign end_off_s      = LEN_W'(aligned_off_s) + len_bytes;
  assign range_bad_s    = (end_off_s > LEN_W'(MEM_BYTES));

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_next   = state_r;
    accept_s     = 1'b0;
    start_bad_s  = 1'b0;
    start_ok_s   = 1'b0;
    start_load_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (range_bad_s) begin
            start_bad_s = 1'b1;
            state_next  = S_IDLE;
          end else if (len_bytes == 13'd0) begin
            start_ok_s = 1'b1;
            state_next = S_DONE;
          end else begin
            start_ok_s   = 1'b1;
            start_load_s = 1'b1;
            state_next   = S_RECV;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RECV: begin
        // in_ready is high for the whole RECV state, so valid alone accepts.
        if (bus.in_valid) begin
          accept_s = 1'b1;
          if ((lane_r == 2'd3) || (remaining_r == 13'd1)) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_RECV;
          end
        end else begin
          state_next = S_RECV;
        end
      end
      S_WRITE: begin
        if (remaining_r != 13'd0) begin
          state_next = S_RECV;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Address, byte counter, lane pointer and word buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r      <= '0;
      remaining_r <= 13'd0;
      lane_r      <= 2'd0;
      word_r      <= '0;
      be_r        <= 4'b0000;
    end else begin
      if (start_load_s) begin
        addr_r      <= aligned_base_s;
        remaining_r <= len_bytes;
        lane_r      <= 2'd0;
        word_r      <= '0;
        be_r        <= 4'b0000;
      end else if (accept_s) begin
        word_r[lane_r] <= bus.in_data;
        be_r[lane_r]   <= 1'b1;
        lane_r         <= lane_r + 2'd1;
        remaining_r    <= remaining_r - 13'd1;
      end else if (state_r == S_WRITE) begin
        // The word has just been presented; start the next one clean.
        addr_r <= addr_r + ADDR_WIDTH'(32'd4);
        lane_r <= 2'd0;
        word_r <= '0;
        be_r   <= 4'b0000;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // Status and strobe outputs, registered from the next state so that each
  // one lines up exactly with the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      busy         <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.in_ready <= (state_next == S_RECV);
      bus.wr_en    <= (state_next == S_WRITE);
      busy         <= (state_next != S_IDLE);
      cpu_hold     <= (state_next != S_IDLE);
      done         <= (state_next == S_DONE);
      err          <= start_bad_s;
    end
  end

  // The write bus shows the working registers directly; they are only
  // meaningful while wr_en is high and unfilled lanes are always zero.
  assign bus.wr_addr = addr_r;
  assign bus.wr_data = DATA_WIDTH'(word_r);
  assign bus.wr_be   = be_r;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_r;

  // Running byte sum; cleared by an accepted start, held after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_r <= 8'h00;
    end else if (start_ok_s) begin
      checksum_r <= 8'h00;
    end else if (accept_s) begin
      checksum_r <= checksum_r + 8'(bus.in_data);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [12:0] len_bytes;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [7:0]  checksum;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_wr_cyc = 0;

  imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus ();

  imem_loader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_BYTES(4096)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .len_bytes(len_bytes), .bus(bus), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct packed {
    logic [7:0] cs;
    logic       had_wr;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    err_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: derives the expected writes / done / err from the
  // byte-level description of a load. Returns 1 if the start is accepted.
  function automatic bit model_load(input logic [31:0] base, input int len,
                                    input logic [7:0] bytes[$]);
    logic [31:0] aligned;
    int          sum;
    wr_t         w;
    done_t       d;
    aligned = base & 32'hFFFF_FFFC;
    if (int'(aligned[11:0]) + len > 4096) begin
      err_pending++;
      return 1'b0;
    end
    sum = 0;
    for (int k = 0; k * 4 < len; k++) begin
      w.addr = aligned + 32'(4 * k);
      w.data = 32'h0;
      w.be   = 4'b0000;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < len) begin
          w.data = w.data | (32'(bytes[4 * k + j]) << (8 * j));
          w.be[j] = 1'b1;
          sum = (sum + int'(bytes[4 * k + j])) % 256;
        end
      end
      wr_q.push_back(w);
    end
`ifdef LOADER_CHECKSUM_EN
    d.cs = 8'(sum);
`else
    d.cs = 8'h00;
`endif
    d.had_wr = (len > 0);
    done_q.push_back(d);
    return 1'b1;
  endfunction

  // Monitor: compares everything the DUT presents against the scoreboard.
  initial begin
    wr_t   w;
    done_t d;
    forever begin
      @(negedge clk);
      cyc++;
      check("cpu_hold_eq_busy", 32'(cpu_hold), 32'(busy));
      if (bus.wr_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write_addr", bus.wr_addr, 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", bus.wr_addr, w.addr);
          check("wr_data", bus.wr_data, w.data);
          check("wr_be", 32'(bus.wr_be), 32'(w.be));
        end
        last_wr_cyc = cyc;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          d = done_q.pop_front();
          check("checksum", 32'(checksum), 32'(d.cs));
          if (d.had_wr) check("done_after_write", 32'(cyc - last_wr_cyc), 32'd1);
        end
      end
      if (err) begin
        check("err_expected", 32'(err_pending > 0), 32'd1);
        if (err_pending > 0) err_pending--;
      end
    end
  end

  task automatic run_load(input logic [31:0] base, input int len, input int mode,
                          input logic [7:0] bytes[$]);
    bit ok;
    int idx;
    int busy_cycles;
    int guard;
    bit v;
    ok = model_load(base, len, bytes);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    len_bytes = 13'(len);
    @(negedge clk);
    start     = 1'b0;
    base_addr = $urandom;
    len_bytes = 13'($urandom);
    if (!ok) begin
      for (int i = 0; i < 3; i++) begin
        check("busy_after_reject", 32'(busy), 32'd0);
        @(negedge clk);
      end
    end else if (len == 0) begin
      check("busy_len0", 32'(busy), 32'd1);
      @(negedge clk);
      check("idle_after_len0", 32'(busy), 32'd0);
    end else begin
      check("in_ready_after_start", 32'(bus.in_ready), 32'd1);
      idx = 0;
      busy_cycles = 0;
      guard = 0;
      while (busy && guard < 8000) begin
        busy_cycles++;
        if (idx < len) begin
          case (mode)
            0: v = 1'b1;
            1: v = (guard % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
          endcase
          bus.in_valid = v;
          bus.in_data  = v ? bytes[idx] : 8'($urandom);
          if (v && bus.in_ready) idx++;
        end else begin
          bus.in_valid = 1'b0;
        end
        @(negedge clk);
        guard++;
      end
      bus.in_valid = 1'b0;
      if (guard >= 8000) check("load_timeout", 32'(busy), 32'd0);
      if (mode == 0) check("busy_cycles", 32'(busy_cycles), 32'(len + (len + 3) / 4 + 1));
    end
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
    check({tag, "_wr_data"}, bus.wr_data, 32'd0);
    check({tag, "_wr_be"}, 32'(bus.wr_be), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [31:0] b;
    int          n;
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = 32'h0;
    len_bytes    = 13'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single word from a fixed stream.
    q = {8'h13, 8'h00, 8'h50, 8'h00};
    run_load(32'h0, 4, 0, q);

    // Unaligned base, partial second word.
    rand_bytes(6, q);
    run_load(32'h102, 6, 0, q);

    // Throttled stream.
    rand_bytes(8, q);
    run_load(32'h0000_0440, 8, 1, q);

    // Out-of-range start is rejected.
    rand_bytes(8, q);
    run_load(32'hFFC, 8, 0, q);

    // Zero-length load.
    q = {};
    run_load(32'h80, 0, 0, q);

    // Reset in the middle of a load: nothing must be written.
    q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    @(negedge clk);
    start = 1'b1; base_addr = 32'h200; len_bytes = 13'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    run_load(32'h200, 4, 0, q);

    // Boundary: last word of memory exactly fits; upper address bits kept.
    rand_bytes(4, q);
    run_load(32'h8000_0FFC, 4, 0, q);

    // Randomized loads, including some rejections.
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(1, 23);
      b = $urandom;
      if ($urandom_range(0, 4) != 0) b[11:0] = 12'($urandom_range(0, 4095 - n));
      rand_bytes(n, q);
      run_load(b, n, $urandom_range(0, 2), q);
    end

    // Full memory image.
    rand_bytes(4096, q);
    run_load(32'h0, 4096, 0, q);

    repeat (5) @(negedge clk);
    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
    check("dones_outstanding", 32'(done_q.size()), 32'd0);
    check("errs_outstanding", 32'(err_pending), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
